counter_bank: RTL and testbench

//  Bank of CHANNELS independent programmable counters. Per-channel enable, direction,

---
 rtl/counter_bank.sv | 248 ++++++++++++++++++++++++
 tb/tb_counter_bank.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
// -----------------------------------------------------------------------------
// counter_bank
//   A bank of CHANNELS independent programmable counters, all configured through
//   one simple valid/wstrb/ready slave port. Each channel has its own enable,
//   direction, wrap/saturate mode, prescaler and (optionally) a compare value
//   with a sticky MATCH flag that can raise irq_o.
//
//   Register map (channel = addr_i[7:4], register = addr_i[3:2]):
//     0 CTRL    [0]EN [1]DOWN [2]SAT [3]IRQ_EN [15:8]PRESCALE
//     1 COUNT
//     2 COMPARE
//     3 STATUS  [0]MATCH [1]OVF, sticky, write-1-to-clear
//   Accesses to channels >= CHANNELS read 0, ignore writes, and are still acked.
//
//   Build option: define COUNTER_BANK_CMP_EN to include the COMPARE registers,
//   the MATCH flag and irq_o. Without it COMPARE reads 0, MATCH is 0 and irq_o
//   is tied low.
//
// Ports
//   clk_i     clock
//   rst_ni    synchronous active-low reset
//   valid_i   bus request
//   wstrb_i   byte write strobes, 0 means read
//   addr_i    byte address, only [7:2] decoded
//   wdata_i   write data
//   freeze_i  global hold for all counters (bus access unaffected)
//   ready_o   one-cycle acknowledge
//   rdata_o   read data, valid while ready_o is high
//   count_o   live counts, channel n at [n*WORD_SIZE +: WORD_SIZE]
//   irq_o     registered OR over channels of MATCH & IRQ_EN
// -----------------------------------------------------------------------------
module counter_bank #(
  parameter int WORD_SIZE     = 32,
  parameter int CHANNELS      = 4,
  parameter int PRESCALE_BITS = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          valid_i,
  input  logic [3:0]                    wstrb_i,
  input  logic [31:0]                   addr_i,
  input  logic [31:0]                   wdata_i,
  input  logic                          freeze_i,
  output logic                          ready_o,
  output logic [31:0]                   rdata_o,
  output logic [CHANNELS*WORD_SIZE-1:0] count_o,
  output logic                          irq_o
);

  localparam logic [WORD_SIZE-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [PRESCALE_BITS-1:0] prescale;
    logic                     irq_en;
    logic                     sat;
    logic                     down;
    logic                     en;
  } ctrl_t;

  ctrl_t                     ctrl_q  [CHANNELS];
  ctrl_t                     ctrl_d  [CHANNELS];
  logic [WORD_SIZE-1:0]      count_q [CHANNELS];
  logic [WORD_SIZE-1:0]      count_d [CHANNELS];
  logic [PRESCALE_BITS-1:0]  pre_q   [CHANNELS];
  logic [PRESCALE_BITS-1:0]  pre_d   [CHANNELS];
  logic [CHANNELS-1:0]       ovf_q, ovf_d;
  logic [CHANNELS-1:0]       match_s;
  logic                      ready_q, ready_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [31:0]               rd_val;

  logic [CHANNELS-1:0]       tick_w;
  logic [CHANNELS-1:0]       wrap_w;
  logic [WORD_SIZE-1:0]      step_w  [CHANNELS];

  logic                      acc;
  logic                      wr;
  logic [3:0]                chan;
  logic [1:0]                reg_sel;
  logic                      unused_addr;

`ifdef COUNTER_BANK_CMP_EN
  logic [WORD_SIZE-1:0]      cmp_q   [CHANNELS];
  logic [WORD_SIZE-1:0]      cmp_d   [CHANNELS];
  logic [CHANNELS-1:0]       match_q, match_d;
  logic                      irq_q, irq_d;
`endif

  // A request is served only when no ack is outstanding, so ready_o can never
  // be high two cycles running and a held request is served every other cycle.
  assign acc         = valid_i && !ready_q;
  assign wr          = acc && (wstrb_i != 4'b0000);
  assign chan        = addr_i[7:4];
  assign reg_sel     = addr_i[3:2];
  assign unused_addr = ^{addr_i[31:8], addr_i[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] ctrl_rd(input ctrl_t c);
    return {16'h0000, 8'(c.prescale), 4'h0, c.irq_en, c.sat, c.down, c.en};
  endfunction

  // Per-channel tick and the value the counter would take on that tick.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      tick_w[n] = ctrl_q[n].en && !freeze_i && (pre_q[n] == ctrl_q[n].prescale);
      if (ctrl_q[n].down) begin
        wrap_w[n] = (count_q[n] == '0);
        step_w[n] = wrap_w[n] ? (ctrl_q[n].sat ? '0 : CNT_MAX)
                              : count_q[n] - WORD_SIZE'(1);
      end else begin
        wrap_w[n] = (count_q[n] == CNT_MAX);
        step_w[n] = wrap_w[n] ? (ctrl_q[n].sat ? CNT_MAX : '0)
                              : count_q[n] + WORD_SIZE'(1);
      end
    end
  end

`ifdef COUNTER_BANK_CMP_EN
  assign match_s = match_q;
`else
  assign match_s = '0;
`endif

  always_comb begin
    ready_d = acc;
    rd_val  = '0;
`ifdef COUNTER_BANK_CMP_EN
    irq_d   = 1'b0;
`endif
    for (int n = 0; n < CHANNELS; n++) begin
      ctrl_d[n]  = ctrl_q[n];
      count_d[n] = count_q[n];
      pre_d[n]   = pre_q[n];

      if (ctrl_q[n].en && !freeze_i) begin
        pre_d[n] = tick_w[n] ? '0 : pre_q[n] + PRESCALE_BITS'(1);
      end
      if (tick_w[n]) begin
        count_d[n] = step_w[n];
      end

      // Flag sets are ORed in after the W1C mask so a set wins a same-cycle clear.
      ovf_d[n] = ovf_q[n] & ~(wr && chan == 4'(n) && reg_sel == 2'd3 &&
                              wstrb_i[0] && wdata_i[1]);
      ovf_d[n] = ovf_d[n] | (tick_w[n] & wrap_w[n]);

`ifdef COUNTER_BANK_CMP_EN
      cmp_d[n]   = cmp_q[n];
      match_d[n] = match_q[n] & ~(wr && chan == 4'(n) && reg_sel == 2'd3 &&
                                  wstrb_i[0] && wdata_i[0]);
      match_d[n] = match_d[n] | (tick_w[n] && step_w[n] == cmp_q[n]);
      irq_d      = irq_d | (match_q[n] & ctrl_q[n].irq_en);
`endif

      if (wr && chan == 4'(n)) begin
        case (reg_sel)
          2'd0: begin
            if (wstrb_i[0]) begin
              {ctrl_d[n].irq_en, ctrl_d[n].sat, ctrl_d[n].down, ctrl_d[n].en} = wdata_i[3:0];
            end
            if (wstrb_i[1]) begin
              ctrl_d[n].prescale = wdata_i[8 +: PRESCALE_BITS];
            end
            pre_d[n] = '0;
          end
          2'd1: begin
            // Bus write overrides any tick in the same cycle.
            count_d[n] = WORD_SIZE'(merge(32'(count_q[n]), wdata_i, wstrb_i));
            pre_d[n]   = '0;
          end
`ifdef COUNTER_BANK_CMP_EN
          2'd2: cmp_d[n] = WORD_SIZE'(merge(32'(cmp_q[n]), wdata_i, wstrb_i));
`endif
          default: ;
        endcase
      end

      if (chan == 4'(n)) begin
        case (reg_sel)
          2'd0:    rd_val = ctrl_rd(ctrl_q[n]);
          2'd1:    rd_val = 32'(count_q[n]);
`ifdef COUNTER_BANK_CMP_EN
          2'd2:    rd_val = 32'(cmp_q[n]);
`endif
          2'd3:    rd_val = {30'b0, ovf_q[n], match_s[n]};
          default: rd_val = '0;
        endcase
      end
    end
    rdata_d = acc ? rd_val : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      ovf_q   <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        ctrl_q[n]  <= '0;
        count_q[n] <= '0;
        pre_q[n]   <= '0;
      end
`ifdef COUNTER_BANK_CMP_EN
      match_q <= '0;
      irq_q   <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) cmp_q[n] <= '0;
`endif
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
      for (int n = 0; n < CHANNELS; n++) begin
        ctrl_q[n]  <= ctrl_d[n];
        count_q[n] <= count_d[n];
        pre_q[n]   <= pre_d[n];
      end
`ifdef COUNTER_BANK_CMP_EN
      match_q <= match_d;
      irq_q   <= irq_d;
      for (int n = 0; n < CHANNELS; n++) cmp_q[n] <= cmp_d[n];
`endif
    end
  end

  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      count_o[n*WORD_SIZE +: WORD_SIZE] = count_q[n];
    end
  end

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;
`ifdef COUNTER_BANK_CMP_EN
  assign irq_o   = irq_q;
`else
  assign irq_o   = 1'b0;
`endif

endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;
  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         valid_i;
  logic [3:0]   wstrb_i;
  logic [31:0]  addr_i;
  logic [31:0]  wdata_i;
  logic         freeze_i;
  logic         ready_o;
  logic [31:0]  rdata_o;
  logic [127:0] count_o;
  logic         irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  counter_bank dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .wstrb_i(wstrb_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .freeze_i(freeze_i), .ready_o(ready_o),
    .rdata_o(rdata_o), .count_o(count_o), .irq_o(irq_o)
  );

  function automatic logic [31:0] ra(input int ch, input int r);
    return 32'(ch * 16 + r * 4);
  endfunction

  function automatic logic [31:0] cnt(input int ch);
    return count_o[ch*32 +: 32];
  endfunction

  // One bus transaction, started at a negedge; returns two negedges later.
  task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] data, output logic [31:0] rd);
    valid_i = 1'b1; addr_i = addr; wstrb_i = strb; wdata_i = data;
    @(negedge clk_i);
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL bus_ack addr=%h ready_o=%b expected 1", addr, ready_o);
    end
    rd = rdata_o;
    valid_i = 1'b0; wstrb_i = 4'h0;
    @(negedge clk_i);
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++; $display("FAIL bus_ack_pulse addr=%h ready_o=%b expected 0", addr, ready_o);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    bus(addr, 4'hF, data, rd);
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    rst_ni = 1'b0; valid_i = 1'b1; addr_i = ra(0, 1); wstrb_i = 4'h0;
    wdata_i = '0; freeze_i = 1'b0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    n_checks++;
    if (count_o !== 128'h0) begin n_fail++; $display("FAIL reset_count got=%h exp=0", count_o); end
    n_checks++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    rst_ni = 1'b1; valid_i = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      for (int r = 0; r < 4; r++) begin
        bus(ra(ch, r), 4'h0, 32'h0, rd);
        n_checks++;
        if (rd !== 32'h0) begin
          n_fail++; $display("FAIL reset_reg ch=%0d reg=%0d got=%h exp=0", ch, r, rd);
        end
      end
    end
  endtask

  task automatic test_handshake_count;
    logic [31:0] rd;
    wr(ra(0, 0), 32'h0000_0001);
    bus(ra(0, 1), 4'h0, 32'h0, rd);
    n_checks++;
    if (rd !== 32'd1) begin n_fail++; $display("FAIL hs_read_count got=%h exp=1", rd); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (cnt(0) !== 32'(3 + k)) begin
        n_fail++; $display("FAIL hs_increment k=%0d got=%h exp=%h", k, cnt(0), 32'(3 + k));
      end
      if (k < 2) @(negedge clk_i);
    end
    wr(ra(0, 0), 32'h0);
    bus(ra(0, 1), 4'h0, 32'h0, rd);
    n_checks++;
    if (rd !== 32'd6) begin n_fail++; $display("FAIL hs_stopped_count got=%h exp=6", rd); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] seen;
    valid_i = 1'b1; addr_i = ra(0, 1); wstrb_i = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      seen[k] = ready_o;
      if (ready_o === 1'b1) begin
        n_checks++;
        if (rdata_o !== 32'd6) begin
          n_fail++; $display("FAIL b2b_rdata k=%0d got=%h exp=6", k, rdata_o);
        end
      end
    end
    valid_i = 1'b0;
    n_checks++;
    if (seen !== 4'b0101) begin n_fail++; $display("FAIL b2b_ready_pattern got=%b exp=0101", seen); end
    @(negedge clk_i);
  endtask

  task automatic test_prescale_wrap;
    logic [31:0] rd;
    wr(ra(1, 2), 32'h1234);
    wr(ra(1, 1), 32'hFFFF_FFFE);
    wr(ra(1, 0), 32'h0000_0301);
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (cnt(1) !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL pw_before_tick got=%h exp=fffffffe", cnt(1)); end
    @(negedge clk_i);
    n_checks++;
    if (cnt(1) !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL pw_tick1 got=%h exp=ffffffff", cnt(1)); end
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (cnt(1) !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL pw_hold got=%h exp=ffffffff", cnt(1)); end
    @(negedge clk_i);
    n_checks++;
    if (cnt(1) !== 32'h0) begin n_fail++; $display("FAIL pw_wrap got=%h exp=0", cnt(1)); end
    wr(ra(1, 0), 32'h0);
    bus(ra(1, 3), 4'h0, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h2) begin n_fail++; $display("FAIL pw_status got=%h exp=2", rd); end
    bus(ra(1, 3), 4'hF, 32'h2, rd);
    n_checks++;
    if (rd !== 32'h2) begin n_fail++; $display("FAIL pw_w1c_prewrite got=%h exp=2", rd); end
    bus(ra(1, 3), 4'h0, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL pw_status_cleared got=%h exp=0", rd); end
  endtask

  task automatic test_saturate_freeze;
    logic [31:0] rd;
    wr(ra(2, 2), 32'hFF);
    wr(ra(2, 1), 32'h1);
    wr(ra(2, 0), 32'h0000_0007);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (cnt(2) !== 32'h0) begin n_fail++; $display("FAIL sat_hold k=%0d got=%h exp=0", k, cnt(2)); end
      @(negedge clk_i);
    end
    bus(ra(2, 3), 4'h0, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h2) begin n_fail++; $display("FAIL sat_status got=%h exp=2", rd); end
    freeze_i = 1'b1;
    wr(ra(2, 0), 32'h0000_0003);
    bus(ra(2, 1), 4'h0, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL frz_read got=%h exp=0", rd); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      n_checks++;
      if (cnt(2) !== 32'h0) begin n_fail++; $display("FAIL frz_hold k=%0d got=%h exp=0", k, cnt(2)); end
    end
    freeze_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (cnt(2) !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL frz_release_wrap got=%h exp=ffffffff", cnt(2)); end
    wr(ra(2, 0), 32'h0);
    bus(ra(2, 1), 4'h0, 32'h0, rd);
    n_checks++;
    if (rd !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL frz_final got=%h exp=fffffffe", rd); end
  endtask

  task automatic test_compare_irq;
    logic [31:0] rd;
`ifdef COUNTER_BANK_CMP_EN
    wr(ra(3, 2), 32'h5);
    wr(ra(3, 0), 32'h0000_0009);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (irq_o !== 1'b0) begin n_fail++; $display("FAIL cmp_irq_early k=%0d got=%b exp=0", k, irq_o); end
      if (k < 4) @(negedge clk_i);
    end
    n_checks++;
    if (cnt(3) !== 32'h5) begin n_fail++; $display("FAIL cmp_count got=%h exp=5", cnt(3)); end
    @(negedge clk_i);
    n_checks++;
    if (irq_o !== 1'b1) begin n_fail++; $display("FAIL cmp_irq_set got=%b exp=1", irq_o); end
    bus(ra(3, 3), 4'hF, 32'h1, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL cmp_status got=%h exp=1", rd); end
    n_checks++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL cmp_irq_clear got=%b exp=0", irq_o); end
    wr(ra(3, 0), 32'h0);
`else
    wr(ra(3, 2), 32'h5);
    wr(ra(3, 0), 32'h0000_0009);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      n_checks++;
      if (irq_o !== 1'b0) begin n_fail++; $display("FAIL nocmp_irq k=%0d got=%b exp=0", k, irq_o); end
    end
    bus(ra(3, 2), 4'h0, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL nocmp_compare got=%h exp=0", rd); end
    bus(ra(3, 3), 4'h0, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL nocmp_status got=%h exp=0", rd); end
    wr(ra(3, 0), 32'h0);
`endif
  endtask

  task automatic test_collision;
    logic [31:0] rd;
    wr(ra(0, 2), 32'h55);
    wr(ra(0, 0), 32'h0000_0001);
    valid_i = 1'b1; addr_i = ra(0, 1); wstrb_i = 4'hF; wdata_i = 32'h100;
    @(negedge clk_i);
    n_checks++;
    if (cnt(0) !== 32'h100) begin n_fail++; $display("FAIL col_write_wins got=%h exp=100", cnt(0)); end
    valid_i = 1'b0; wstrb_i = 4'h0;
    @(negedge clk_i);
    n_checks++;
    if (cnt(0) !== 32'h101) begin n_fail++; $display("FAIL col_next_tick got=%h exp=101", cnt(0)); end
    wr(ra(0, 0), 32'h0000_0101);
    valid_i = 1'b1; addr_i = ra(0, 1); wstrb_i = 4'hF; wdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL col_ack1 got=%b exp=1", ready_o); end
    addr_i = ra(0, 3); wdata_i = 32'h2;
    @(negedge clk_i);
    n_checks++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL col_gap got=%b exp=0", ready_o); end
    @(negedge clk_i);
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL col_ack2 got=%b exp=1", ready_o); end
    n_checks++;
    if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL col_prewrite_status got=%h exp=0", rdata_o); end
    n_checks++;
    if (cnt(0) !== 32'h0) begin n_fail++; $display("FAIL col_wrapped got=%h exp=0", cnt(0)); end
    valid_i = 1'b0; wstrb_i = 4'h0;
    @(negedge clk_i);
    wr(ra(0, 0), 32'h0);
    bus(ra(0, 3), 4'h0, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h2) begin n_fail++; $display("FAIL col_flag_kept got=%h exp=2", rd); end
    wr(ra(0, 3), 32'h2);
    bus(ra(0, 3), 4'h0, 32'h0, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL col_flag_cleared got=%h exp=0", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_handshake_count();
    test_back_to_back();
    test_prescale_wrap();
    test_saturate_freeze();
    test_compare_irq();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
